// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - UART transmitter with configurable frame format and write FIFO
//
// Purpose: accepts words on a valid/ready write port into a small FIFO and
// serialises them as start / data (LSB first) / optional parity / stop bits.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   en         - transmit enable; gates only the start of new frames
//   s_valid    - write word offered
//   s_data     - word to transmit (DATA_BITS wide)
//   s_ready    - FIFO can accept a word
//   tx         - registered serial line, idle high
//   tx_busy    - high from first start-bit cycle through last stop-bit cycle
//   fifo_count - FIFO occupancy
module uart_tx_cfg #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         s_valid,
  input  logic [DATA_BITS-1:0]         s_data,
  output logic                         s_ready,
  output logic                         tx,
  output logic                         tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int CNT_W = $clog2(STOP_BITS * DIV + 1);
  localparam int BW    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS * DIV - 1);
  localparam logic [BW-1:0]    LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0]    FULL     = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t state, state_n;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 wr, pop, bit_done, stop_done;
  logic                 tx_d;

  assign s_ready   = (fifo_count < FULL);
  assign wr        = s_valid & s_ready;
  assign pop       = (state == S_IDLE) & en & (fifo_count != '0);
  assign bit_done  = (baud_cnt == BIT_END);
  assign stop_done = (baud_cnt == STOP_END);

  // FIFO storage needs no reset: emptiness is defined by the pointers/count.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({wr, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (pop) state_n = S_START;
      S_START:  if (bit_done) state_n = S_DATA;
      S_DATA:   if (bit_done && bit_idx == LAST_BIT)
                  state_n = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_done) state_n = S_STOP;
      S_STOP:   if (stop_done) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Baud counter restarts with every frame and every bit; the stop phase is
  // timed as one long interval of STOP_BITS bit periods. Parity is captured
  // from the unshifted word at pop time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else if (pop) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= mem[rd_ptr];
      par_bit  <= (^mem[rd_ptr]) ^ (PARITY == 1);
    end else if (state != S_IDLE) begin
      if ((state == S_STOP) ? stop_done : bit_done) baud_cnt <= '0;
      else                                          baud_cnt <= baud_cnt + CNT_W'(1);
      if (state == S_DATA && bit_done) begin
        bit_idx <= bit_idx + BW'(1);
        shreg   <= shreg >> 1;
      end
    end
  end

  // Output logic: the value tx takes on the next cycle, so the line is
  // driven straight from a flop and changes exactly on bit boundaries.
  always_comb begin
    tx_d = tx;
    case (state)
      S_IDLE:   tx_d = pop ? 1'b0 : 1'b1;
      S_START:  if (bit_done) tx_d = shreg[0];
      S_DATA:   if (bit_done)
                  tx_d = (bit_idx == LAST_BIT) ? ((PARITY != 0) ? par_bit : 1'b1)
                                               : shreg[1];
      S_PARITY: if (bit_done) tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      tx      <= tx_d;
      tx_busy <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - Scoreboard testbench for uart_tx_cfg (four frame formats)
module tb_uart_tx_cfg;

  localparam int NI  = 4;
  localparam int DIV = 10;

  function automatic int db_of(int k);
    return (k == 1 || k == 2) ? 7 : 8;
  endfunction
  function automatic int par_of(int k);
    return (k == 1) ? 2 : (k == 2) ? 1 : 0;
  endfunction
  function automatic int sb_of(int k);
    return (k == 3) ? 2 : 1;
  endfunction
  function automatic int flen_of(int k);
    return (1 + db_of(k) + ((par_of(k) != 0) ? 1 : 0) + sb_of(k)) * DIV;
  endfunction

  // Reference: level of the serial line during bit slot 'slot' of a frame.
  function automatic logic exp_bit(int k, logic [8:0] w, int slot);
    int db;
    int pb;
    int ones;
    db   = db_of(k);
    pb   = par_of(k);
    ones = $countones(w);
    if (slot == 0) return 1'b0;
    if (slot <= db) return w[slot-1];
    if (pb != 0 && slot == db + 1) return (pb == 2) ? 1'(ones % 2) : 1'(1 - ones % 2);
    return 1'b1;
  endfunction

  logic clk = 1'b0;
  logic [NI-1:0] rst, en, s_valid, s_ready, tx, tx_busy;
  logic [8:0] s_data [NI];
  logic [NI-1:0][2:0] fifo_count;
  logic [8:0] exp_q [NI][$];
  int start_q [NI][$];
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DB = db_of(g);
    localparam int PB = par_of(g);
    localparam int SB = sb_of(g);
    localparam int FL = flen_of(g);

    uart_tx_cfg #(
      .CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(DB),
      .PARITY(PB), .STOP_BITS(SB), .FIFO_DEPTH(4)
    ) u_dut (
      .clk(clk), .rst(rst[g]), .en(en[g]), .s_valid(s_valid[g]),
      .s_data(s_data[g][DB-1:0]), .s_ready(s_ready[g]), .tx(tx[g]),
      .tx_busy(tx_busy[g]), .fifo_count(fifo_count[g])
    );

    logic wav [FL];
    logic bsy [FL];

    // Monitor: captures each frame from its falling start edge and compares
    // it with the next word the stimulus queued.
    initial begin : mon
      logic prev_tx, prev_busy, pb0, abort, eb;
      logic [8:0] w;
      int bad, nb;
      prev_tx = 1'b1;
      prev_busy = 1'b0;
      forever begin
        @(negedge clk);
        if (rst[g] !== 1'b0) begin
          prev_tx = 1'b1;
          prev_busy = 1'b0;
        end else if (prev_tx === 1'b1 && tx[g] === 1'b0) begin
          start_q[g].push_back(cyc);
          pb0 = prev_busy;
          abort = 1'b0;
          wav[0] = tx[g];
          bsy[0] = tx_busy[g];
          for (int j = 1; j <= FL && !abort; j++) begin
            @(negedge clk);
            if (rst[g] !== 1'b0) abort = 1'b1;
            else if (j < FL) begin
              wav[j] = tx[g];
              bsy[j] = tx_busy[g];
            end
          end
          if (abort) begin
            prev_tx = 1'b1;
            prev_busy = 1'b0;
          end else begin
            prev_tx = tx[g];
            prev_busy = tx_busy[g];
            chk($sformatf("u%0d frame expected", g), int'(exp_q[g].size() > 0), 1);
            if (exp_q[g].size() > 0) begin
              w = exp_q[g].pop_front();
              bad = -1;
              nb = 0;
              for (int j = 0; j < FL; j++) begin
                eb = exp_bit(g, w, j / DIV);
                if (wav[j] !== eb && bad < 0) bad = j;
                if (bsy[j] === 1'b1) nb++;
              end
              chk($sformatf("u%0d word %0h first bad tx cycle", g, w), bad, -1);
              chk($sformatf("u%0d busy cycles", g), nb, FL);
              chk($sformatf("u%0d busy before frame", g), int'(pb0), 0);
              chk($sformatf("u%0d busy/tx after frame", g), int'({prev_busy, prev_tx}), 1);
            end
          end
        end else begin
          prev_tx = tx[g];
          prev_busy = tx_busy[g];
        end
      end
    end
  end

  task automatic put(int k, logic [8:0] w);
    int t;
    logic [8:0] m;
    m = w & ((9'h1 << db_of(k)) - 9'h1);
    t = 0;
    while (s_ready[k] !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk($sformatf("u%0d s_ready timeout", k), int'(s_ready[k]), 1);
    s_valid[k] = 1'b1;
    s_data[k] = m;
    exp_q[k].push_back(m);
    @(negedge clk);
    s_valid[k] = 1'b0;
  endtask

  task automatic drain(int k);
    int t;
    t = 0;
    while ((exp_q[k].size() != 0 || tx_busy[k] !== 1'b0 || fifo_count[k] != 3'd0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("u%0d queue drained", k), exp_q[k].size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_start(int k);
    int t;
    t = 0;
    while (tx[k] !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("u%0d start bit seen", k), int'(tx[k]), 0);
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin : stim
    int ok, tot, t;
    logic [8:0] w5;
    rst = '1;
    en = '0;
    s_valid = '0;
    for (int k = 0; k < NI; k++) s_data[k] = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d reset tx", k), int'(tx[k]), 1);
      chk($sformatf("u%0d reset busy", k), int'(tx_busy[k]), 0);
      chk($sformatf("u%0d reset count", k), int'(fifo_count[k]), 0);
      chk($sformatf("u%0d reset ready", k), int'(s_ready[k]), 1);
    end
    rst = '0;
    @(negedge clk);

    // 0xA5, 8N1: pop latency and 100-cycle frame
    en[0] = 1'b1;
    put(0, 9'h0A5);
    chk("a5 count after write", int'(fifo_count[0]), 1);
    chk("a5 tx before pop", int'(tx[0]), 1);
    @(negedge clk);
    chk("a5 count after pop", int'(fifo_count[0]), 0);
    chk("a5 tx low after pop", int'(tx[0]), 0);
    chk("a5 busy after pop", int'(tx_busy[0]), 1);
    drain(0);

    // 7-bit even and odd parity on word 0x03
    en[1] = 1'b1;
    en[2] = 1'b1;
    put(1, 9'h003);
    put(2, 9'h003);
    drain(1);
    drain(2);

    // Two stop bits, back-to-back frames
    start_q[3].delete();
    put(3, 9'h055);
    put(3, 9'h00F);
    en[3] = 1'b1;
    drain(3);
    chk("b2b frames seen", start_q[3].size(), 2);
    if (start_q[3].size() == 2)
      chk("b2b start spacing", start_q[3][1] - start_q[3][0], flen_of(3) + 1);

    // FIFO full while disabled
    en[0] = 1'b0;
    for (int i = 0; i < 4; i++) put(0, 9'($urandom));
    chk("full count", int'(fifo_count[0]), 4);
    chk("full ready", int'(s_ready[0]), 0);
    w5 = 9'($urandom);
    s_valid[0] = 1'b1;
    s_data[0] = w5;
    @(negedge clk);
    s_valid[0] = 1'b0;
    chk("full count after 5th", int'(fifo_count[0]), 4);
    en[0] = 1'b1;
    drain(0);

    // en dropped mid-DATA
    en[0] = 1'b0;
    put(0, 9'($urandom));
    put(0, 9'($urandom));
    en[0] = 1'b1;
    wait_start(0);
    repeat (35) @(negedge clk);
    en[0] = 1'b0;
    ok = 0;
    tot = 0;
    t = 0;
    while (tx_busy[0] === 1'b1 && t < 200) begin
      if (fifo_count[0] == 3'd1) ok++;
      tot++;
      @(negedge clk);
      t++;
    end
    chk("en-low frame completes", int'(tx_busy[0]), 0);
    chk("en-low count held in frame", ok, tot);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx[0] === 1'b1 && tx_busy[0] === 1'b0 && fifo_count[0] == 3'd1) ok++;
    end
    chk("en-low idle cycles", ok, 40);
    en[0] = 1'b1;
    drain(0);

    // Asynchronous reset during DATA with two words queued
    en[0] = 1'b0;
    for (int i = 0; i < 3; i++) put(0, 9'($urandom));
    en[0] = 1'b1;
    wait_start(0);
    repeat (25) @(negedge clk);
    #2;
    rst[0] = 1'b1;
    #1;
    chk("async rst tx", int'(tx[0]), 1);
    chk("async rst busy", int'(tx_busy[0]), 0);
    chk("async rst count", int'(fifo_count[0]), 0);
    chk("async rst ready", int'(s_ready[0]), 1);
    exp_q[0].delete();
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx[0] === 1'b1 && tx_busy[0] === 1'b0) ok++;
    end
    chk("silent after rst", ok, 300);

    // Randomised traffic on all formats, with enable pulses on u0
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < NI; k++) put(k, 9'($urandom));
      en[0] = 1'b0;
      repeat ($urandom_range(0, 40)) @(negedge clk);
      en[0] = 1'b1;
    end
    for (int k = 0; k < NI; k++) drain(k);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
